// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config
// Walks an internal register table and writes each entry to an OV7670 over
// SCCB (3-phase write: ID byte, register address, register data).
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous active-high reset; restarts with the power-up wait
//   start      one-cycle pulse; aborts any activity and replays from entry 0
//   SCL, SDA   SCCB clock/data, push-pull, both high when the bus is idle
//   busy       high while a table entry is being processed or waited on
//   done       high once the terminator entry has been reached
//   entry_idx  index of the table entry currently being processed
//
// Table encoding: {reg_addr, reg_data}. 16'hFFF0 is a 10 ms pause with the
// bus idle. 16'hFFFF ends the table.
//
// Bit timing: every bit is four quarter periods of DIV clocks.
//   Q0 SCL low, SDA takes the new bit
//   Q1 SCL high
//   Q2 SCL high
//   Q3 SCL low
// START is two quarters: SDA low with SCL high, then SCL low.
// STOP is two quarters: SDA low with SCL low, then SCL high. SDA rises on
// entry to GAP.
// The 9th (ACK) bit of each byte is driven high and never sampled.
// DIV must be at least 2.
module ov7670_sccb_config #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned SCL_FREQ = 100_000,
  parameter int unsigned PWR_WAIT = 1_000_000,
  parameter logic [7:0]  DEV_ADDR = 8'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       SCL,
  output logic       SDA,
  output logic       busy,
  output logic       done,
  output logic [7:0] entry_idx
);

  localparam int unsigned DIV       = CLK_FREQ / (4 * SCL_FREQ);
  localparam int unsigned DELAY_CYC = CLK_FREQ / 100;
  localparam logic [31:0] DIV_LAST   = 32'(DIV - 1);
  localparam logic [31:0] PWR_LAST   = (PWR_WAIT == 0)  ? 32'd0 : 32'(PWR_WAIT - 1);
  localparam logic [31:0] DELAY_LAST = (DELAY_CYC == 0) ? 32'd0 : 32'(DELAY_CYC - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_PWR_WAIT, ST_FETCH, ST_START, ST_BYTE,
    ST_STOP, ST_GAP, ST_DELAY, ST_DONE
  } state_t;

  state_t      state;
  logic [31:0] div_cnt;      // clocks within the current quarter period
  logic [31:0] cnt;          // power-up wait and 10 ms pause counter
  logic [1:0]  quarter;
  logic [3:0]  bit_idx;      // 0..7 data bits MSB first, 8 = ACK slot
  logic [1:0]  byte_idx;     // 0 = ID, 1 = reg_addr, 2 = reg_data
  logic [23:0] tx_word;
  logic [15:0] rom_q;
  logic        fetch_ready;  // rom_q reflects entry_idx
  logic        qtick;

  assign qtick = (div_cnt == DIV_LAST);

  function automatic logic [15:0] rom_lookup(input logic [7:0] a);
    case (a)
      8'd0:    rom_lookup = 16'h1280;  // COM7 soft reset
      8'd1:    rom_lookup = 16'hFFF0;  // let the sensor settle after reset
      8'd2:    rom_lookup = 16'h1214;  // COM7: QVGA, RGB output
      8'd3:    rom_lookup = 16'h8C02;  // RGB444 enable, xR GB word order
      8'd4:    rom_lookup = 16'h0400;  // COM1
      8'd5:    rom_lookup = 16'h40D0;  // COM15: full output range
      8'd6:    rom_lookup = 16'h3A04;  // TSLB
      8'd7:    rom_lookup = 16'h1716;  // HSTART
      8'd8:    rom_lookup = 16'h1804;  // HSTOP
      8'd9:    rom_lookup = 16'h3224;  // HREF
      8'd10:   rom_lookup = 16'h1902;  // VSTART
      8'd11:   rom_lookup = 16'h1A7A;  // VSTOP
      8'd12:   rom_lookup = 16'h030A;  // VREF
      default: rom_lookup = 16'hFFFF;
    endcase
  endfunction

  // Select the bus level for one bit slot. The ACK slot is driven high.
  function automatic logic tx_bit(input logic [23:0] w, input logic [1:0] b,
                                  input logic [3:0] i);
    logic [7:0] byte_sel;
    case (b)
      2'd0:    byte_sel = w[23:16];
      2'd1:    byte_sel = w[15:8];
      default: byte_sel = w[7:0];
    endcase
    if (i >= 4'd8) tx_bit = 1'b1;
    else           tx_bit = byte_sel[3'(4'd7 - i)];
  endfunction

  always_ff @(posedge clk) begin
    rom_q <= rom_lookup(entry_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_PWR_WAIT;
      SCL         <= 1'b1;
      SDA         <= 1'b1;
      busy        <= 1'b1;
      done        <= 1'b0;
      entry_idx   <= 8'd0;
      div_cnt     <= 32'd0;
      cnt         <= 32'd0;
      quarter     <= 2'd0;
      bit_idx     <= 4'd0;
      byte_idx    <= 2'd0;
      tx_word     <= 24'd0;
      fetch_ready <= 1'b0;
    end else if (start) begin
      // Abort without a STOP: release the bus and replay from entry 0.
      state       <= ST_FETCH;
      SCL         <= 1'b1;
      SDA         <= 1'b1;
      busy        <= 1'b1;
      done        <= 1'b0;
      entry_idx   <= 8'd0;
      div_cnt     <= 32'd0;
      cnt         <= 32'd0;
      quarter     <= 2'd0;
      bit_idx     <= 4'd0;
      byte_idx    <= 2'd0;
      fetch_ready <= 1'b0;
    end else begin
      div_cnt <= qtick ? 32'd0 : div_cnt + 32'd1;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
        end
        ST_PWR_WAIT: begin
          if (cnt >= PWR_LAST) begin
            state       <= ST_FETCH;
            cnt         <= 32'd0;
            fetch_ready <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_FETCH: begin
          if (!fetch_ready) begin
            fetch_ready <= 1'b1;
          end else begin
            fetch_ready <= 1'b0;
            if (rom_q == 16'hFFFF) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (rom_q == 16'hFFF0) begin
              state <= ST_DELAY;
              cnt   <= 32'd0;
            end else begin
              // SDA falls while SCL is still high: START condition.
              state    <= ST_START;
              tx_word  <= {DEV_ADDR, rom_q};
              SDA      <= 1'b0;
              quarter  <= 2'd0;
              div_cnt  <= 32'd0;
              bit_idx  <= 4'd0;
              byte_idx <= 2'd0;
            end
          end
        end
        ST_START: begin
          if (qtick) begin
            if (quarter == 2'd0) begin
              quarter <= 2'd1;
              SCL     <= 1'b0;
            end else begin
              state   <= ST_BYTE;
              quarter <= 2'd0;
              SDA     <= tx_bit(tx_word, 2'd0, 4'd0);
            end
          end
        end
        ST_BYTE: begin
          if (qtick) begin
            quarter <= quarter + 2'd1;
            case (quarter)
              2'd0: SCL <= 1'b1;
              2'd1: SCL <= 1'b1;
              2'd2: SCL <= 1'b0;
              default: begin
                // End of bit: SCL is already low, so SDA may change here.
                if (bit_idx != 4'd8) begin
                  bit_idx <= bit_idx + 4'd1;
                  SDA     <= tx_bit(tx_word, byte_idx, bit_idx + 4'd1);
                end else if (byte_idx != 2'd2) begin
                  byte_idx <= byte_idx + 2'd1;
                  bit_idx  <= 4'd0;
                  SDA      <= tx_bit(tx_word, byte_idx + 2'd1, 4'd0);
                end else begin
                  state <= ST_STOP;
                  SDA   <= 1'b0;
                end
              end
            endcase
          end
        end
        ST_STOP: begin
          if (qtick) begin
            if (quarter == 2'd0) begin
              quarter <= 2'd1;
              SCL     <= 1'b1;
            end else begin
              // SDA rises while SCL is high: STOP condition.
              state   <= ST_GAP;
              quarter <= 2'd0;
              SDA     <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (qtick) begin
            quarter <= quarter + 2'd1;
            if (quarter == 2'd3) begin
              if (entry_idx == 8'hFF) begin
                // A full table without a terminator still finishes.
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                entry_idx   <= entry_idx + 8'd1;
                state       <= ST_FETCH;
                fetch_ready <= 1'b0;
              end
            end
          end
        end
        ST_DELAY: begin
          if (cnt >= DELAY_LAST) begin
            state   <= ST_GAP;
            cnt     <= 32'd0;
            quarter <= 2'd0;
            div_cnt <= 32'd0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_DONE: begin
          SCL <= 1'b1;
          SDA <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config with DIV = 2, PWR_WAIT = 10 and a 4-cycle pause.
// A bus monitor decodes SCCB writes from SCL/SDA, sampled on the falling
// clock edge. It also checks bit timing and where SDA is allowed to change.
// Expected writes come from a per-entry vector table and from a model that
// walks the register list. Inputs are driven 1 time unit after a rising edge.
module tb_ov7670_sccb_config;

  localparam int CLK_FREQ  = 400;
  localparam int SCL_FREQ  = 50;
  localparam int PWR_WAIT  = 10;
  localparam int DIV       = CLK_FREQ / (4 * SCL_FREQ);
  localparam int DELAY_CYC = CLK_FREQ / 100;
  localparam int GAP_CYC   = 4 * DIV;
  localparam int FETCH_CYC = 2;  // index registered, then ROM output registered
  localparam int STEP_GAP  = GAP_CYC + FETCH_CYC;          // STOP to next START
  localparam int DELAY_ADD = FETCH_CYC + DELAY_CYC + GAP_CYC;  // per pause entry

  logic       clk, reset, start;
  logic       SCL, SDA, busy, done;
  logic [7:0] entry_idx;

  ov7670_sccb_config #(
    .CLK_FREQ(CLK_FREQ), .SCL_FREQ(SCL_FREQ), .PWR_WAIT(PWR_WAIT), .DEV_ADDR(8'h42)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .SCL(SCL), .SDA(SDA),
    .busy(busy), .done(done), .entry_idx(entry_idx)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [15:0] rom_img [14];
  logic [23:0] exp_q[$];
  int          exp_gap_q[$];
  int          exp_idx_q[$];
  int          term_idx;

  // The register list as a plain list: skip pauses, stop at the terminator.
  task automatic build_model();
    int pend;
    bit first;
    logic [15:0] e;
    exp_q.delete(); exp_gap_q.delete(); exp_idx_q.delete();
    pend = 0; first = 1; term_idx = 255;
    for (int i = 0; i < 256; i++) begin
      e = (i < 14) ? rom_img[i] : 16'hFFFF;
      if (e == 16'hFFFF) begin
        term_idx = i;
        break;
      end
      if (e == 16'hFFF0) begin
        pend++;
      end else begin
        exp_q.push_back({8'h42, e});
        exp_idx_q.push_back(i);
        if (!first) exp_gap_q.push_back(STEP_GAP + pend * DELAY_ADD);
        first = 0;
        pend  = 0;
      end
    end
  endtask

  // ---------------- bus monitor ----------------
  logic [23:0] got_q[$];
  int          gap_q[$];
  int          sidx_q[$];
  logic        prev_scl = 1'b1, prev_sda = 1'b1, skip = 1'b1;
  logic        mon_in_tx = 1'b0, rise_ok = 1'b0, fall_ok = 1'b0, have_stop = 1'b0;
  int          mon_bits = 0, cyc = 0, last_rise = 0, last_fall = 0, stop_cyc = 0;
  logic [27:0] shreg = '0;

  always @(negedge clk) begin
    cyc++;
    check("done_busy_exclusive", {31'd0, done & busy}, 32'd0);
    if (reset || start) begin
      mon_in_tx = 0; mon_bits = 0; have_stop = 0; rise_ok = 0; fall_ok = 0; skip = 1;
    end else if (skip) begin
      skip = 0;
    end else if (prev_scl && SCL && (prev_sda !== SDA)) begin
      if (!SDA) begin
        check("start_on_idle_bus", {31'd0, mon_in_tx}, 32'd0);
        if (have_stop) gap_q.push_back(cyc - stop_cyc);
        sidx_q.push_back(int'(entry_idx));
        mon_in_tx = 1; mon_bits = 0; rise_ok = 0; fall_ok = 0;
      end else begin
        // The STOP's own SCL rise is counted as a 28th bit.
        check("stop_after_27_bits", mon_bits, 28);
        if (mon_in_tx && mon_bits == 28)
          got_q.push_back({shreg[27:20], shreg[18:11], shreg[9:2]});
        mon_in_tx = 0; mon_bits = 0; have_stop = 1; stop_cyc = cyc; rise_ok = 0; fall_ok = 0;
      end
    end else if (prev_scl !== SCL) begin
      check("sda_stable_at_scl_edge", {31'd0, SDA}, {31'd0, prev_sda});
      if (SCL) begin
        if (mon_in_tx) begin
          if (fall_ok) check("scl_low_len", cyc - last_fall, 2 * DIV);
          shreg = {shreg[26:0], SDA};
          mon_bits++;
          if (mon_bits % 9 == 0) check("ack_slot_high", {31'd0, SDA}, 32'd1);
          rise_ok = 1; last_rise = cyc;
        end
      end else begin
        check("scl_fall_inside_write", {31'd0, mon_in_tx}, 32'd1);
        if (rise_ok) check("scl_high_len", cyc - last_rise, 2 * DIV);
        fall_ok = 1; last_fall = cyc;
      end
    end
    prev_scl = SCL;
    prev_sda = SDA;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_capture();
    got_q.delete(); gap_q.delete(); sidx_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  // Further falling-edge samples with SDA high before the first START.
  task automatic count_idle(output int n);
    n = 0;
    @(negedge clk);
    while (SDA && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Called on the first falling edge after an abort or reset pulse.
  task automatic check_released(input string name);
    check({name, "_scl"},  {31'd0, SCL},  32'd1);
    check({name, "_sda"},  {31'd0, SDA},  32'd1);
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_idx"},  {24'd0, entry_idx}, 32'd0);
  endtask

  task automatic check_run(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check({name, "_word"}, {8'd0, got_q[k]}, {8'd0, exp_q[k]});
      if (k < sidx_q.size()) check({name, "_idx"}, sidx_q[k], exp_idx_q[k]);
    end
    for (int k = 0; k < exp_gap_q.size() && k < gap_q.size(); k++)
      check({name, "_gap"}, gap_q[k], exp_gap_q[k]);
    check({name, "_done_idx"}, {24'd0, entry_idx}, term_idx);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int          entry;  // table index active when the write starts
    logic [23:0] word;   // {ID, reg_addr, reg_data}
    int          gap;    // idle cycles from the previous STOP; -1 for none
  } vec_t;
  vec_t vecs [12];

  initial begin
    int n, len, idle;
    logic bad;
    reset = 1'b1;
    start = 1'b0;

    rom_img = '{16'h1280, 16'hFFF0, 16'h1214, 16'h8C02, 16'h0400, 16'h40D0, 16'h3A04,
                16'h1716, 16'h1804, 16'h3224, 16'h1902, 16'h1A7A, 16'h030A, 16'hFFFF};
    vecs = '{'{0, 24'h421280, -1}, '{2, 24'h421214, 24}, '{3, 24'h428C02, 10},
             '{4, 24'h420400, 10}, '{5, 24'h4240D0, 10}, '{6, 24'h423A04, 10},
             '{7, 24'h421716, 10}, '{8, 24'h421804, 10}, '{9, 24'h423224, 10},
             '{10, 24'h421902, 10}, '{11, 24'h421A7A, 10}, '{12, 24'h42030A, 10}};
    build_model();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_released("reset");
    clear_capture();
    @(posedge clk); #1 reset = 1'b0;

    // Power-up wait, then FETCH of entry 0 and the first START.
    count_idle(idle);
    check("powerup_idle_cycles", idle, PWR_WAIT + FETCH_CYC);

    // Pause entry: the bus stays idle for the whole time entry 1 is current.
    n = 0;
    while (entry_idx != 8'd1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("reach_entry1", {24'd0, entry_idx}, 32'd1);
    len = 0; bad = 0;
    while (entry_idx == 8'd1 && len < 100) begin
      if (!(SCL && SDA && busy && !done)) bad = 1;
      len++;
      @(negedge clk);
    end
    check("pause_bus_idle_busy", {31'd0, bad}, 32'd0);
    check("pause_window_len", len, FETCH_CYC + DELAY_CYC + GAP_CYC);

    // Full run against the vector table.
    wait_done("full_run_done", 6000);
    check("vec_count", got_q.size(), 12);
    for (int k = 0; k < 12; k++) begin
      if (k < got_q.size()) begin
        check("vec_word", {8'd0, got_q[k]}, {8'd0, vecs[k].word});
        check("vec_entry", sidx_q[k], vecs[k].entry);
        if (vecs[k].gap >= 0 && k - 1 < gap_q.size())
          check("vec_gap", gap_q[k - 1], vecs[k].gap);
      end else begin
        check("vec_missing", k, got_q.size());
      end
    end
    check_run("model_first_run");

    // Quiet bus after the terminator.
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!(SCL && SDA && done && !busy)) bad = 1;
    end
    check("quiet_after_done", {31'd0, bad}, 32'd0);

    // Abort during bit 3 of the reg_addr byte of entry 5.
    clear_capture();
    pulse_start();
    n = 0;
    while (!(entry_idx == 8'd5 && mon_in_tx && mon_bits == 13) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("reach_entry5_bit", mon_bits, 13);
    pulse_start();
    clear_capture();
    @(negedge clk);
    check_released("abort");
    count_idle(idle);
    check("abort_to_start_cycles", 1 + idle, FETCH_CYC);
    n = 0;
    while (got_q.size() == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("abort_first_word", (got_q.size() > 0) ? {8'd0, got_q[0]} : 32'hDEAD, 32'h421280);

    // Reset in the middle of a write: no STOP, power-up wait again.
    n = 0;
    while (!(mon_in_tx && mon_bits == 15) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_mid_write", mon_bits, 15);
    pulse_reset();
    clear_capture();
    @(negedge clk);
    check_released("midreset");
    count_idle(idle);
    check("midreset_idle_cycles", 1 + idle, PWR_WAIT + FETCH_CYC);
    n = 0;
    while (got_q.size() == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midreset_first_word", (got_q.size() > 0) ? {8'd0, got_q[0]} : 32'hDEAD, 32'h421280);

    // Random interruptions, each followed by a full run checked against the model.
    for (int it = 0; it < 3; it++) begin
      pulse_start();
      repeat ($urandom_range(30, 2500)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) pulse_reset();
      else                           pulse_start();
      clear_capture();
      wait_done("random_run_done", 8000);
      check_run("random_run");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
